ps2_tx: RTL and testbench
=========================

// Module: ps2_tx
// PURPOSE
//  Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) to the keyboard.
//  Counterpart of the PS/2 receive path; shares the ps2c/ps2d pads through open-drain enables.
//  Sits beside the receiver in the keyboard subsystem, on the main system clock.
// PARAMETERS
//  CLK_FREQ_HZ  65_000_000  system clock frequency; derives all timing counts
//  INHIBIT_US   100         host clock-inhibit (request-to-send) duration, us
//  TIMEOUT_US   2000        max wait for any device clock edge before abort, us
// PORTS
//  clk           in   1  system clock
//  rst           in   1  synchronous reset, active-high
//  wr_ps2        in   1  one-cycle strobe: start sending din; ignored unless tx_idle=1
//  din           in   8  command byte, captured on an accepted wr_ps2
//  ps2c_in       in   1  raw PS/2 clock pad input (asynchronous)
//  ps2d_in       in   1  raw PS/2 data pad input (asynchronous)
//  ps2c_oe       out  1  1 = drive PS/2 clock low, 0 = release (pad top level: oe ? 1'b0 : 'z)
//  ps2d_oe       out  1  1 = drive PS/2 data low, 0 = release
//  tx_idle       out  1  1 = ready for wr_ps2; receiver must ignore line activity while 0
//  tx_done_tick  out  1  one-cycle pulse: frame sent, bus back to idle
//  tx_error      out  1  one-cycle pulse: timeout (or bad ack, see CONFIGURATION)
// BEHAVIOUR
//  - All outputs registered. Reset values: ps2c_oe=0, ps2d_oe=0, tx_idle=1, tx_done_tick=0, tx_error=0.
//  - Reset in any state releases both lines the next cycle and returns to IDLE; no partial frame resumes.
//  - ps2c_in: 2-FF synchroniser, then an 8-sample glitch filter. The filtered level changes only after 8 equal samples.
//  - fall_edge = filtered level 1 -> 0, one-cycle.
//  - Frame register: {par, din}, with par = ~^din (odd parity). Bit counter n counts 0..9.
//  - IDLE:  tx_idle=1. On wr_ps2: capture frame, load timer=INHIBIT_US*CLK_FREQ_HZ/1e6, go to RTS. tx_idle goes 0 the next cycle.
//  - RTS:   ps2c_oe=1, ps2d_oe=0. At timer 0: set ps2d_oe=1 (start bit); go to START.
//  - START: ps2c_oe=0, ps2d_oe=1. On fall_edge: put frame[0] on the line (ps2d_oe = ~bit), n=1; go to DATA.
//  - DATA:  on each fall_edge, while n<=8: put frame[n] on the line and increment n (data LSB first, then parity).
//           On the fall_edge with n==9: ps2d_oe=0 (stop bit, line released); go to ACK.
//  - ACK:   on fall_edge: sample the synchronised ps2d (device ack, expected 0); go to WAIT.
//  - WAIT:  when filtered ps2c==1 and synchronised ps2d==1: pulse tx_done_tick; go to IDLE.
//  - Timeout: in START/DATA/ACK/WAIT, timer reloads to TIMEOUT_US*CLK_FREQ_HZ/1e6 on each fall_edge and on state entry.
//    At timer 0: release both lines, pulse tx_error, go to IDLE. No tx_done_tick.
//  - wr_ps2 while tx_idle=0: dropped, no queueing. wr_ps2 in the same cycle as tx_done_tick: dropped.
//  - Timer width: $clog2(max(inhibit, timeout) count + 1). Counts are computed at elaboration time in 64-bit arithmetic.
// CONFIGURATION
//  PS2_TX_ACK_CHECK_EN defined: in ACK, a sampled ps2d==1 (no ack) pulses tx_error in the WAIT exit cycle
//    instead of tx_done_tick.
//  Not defined: the ack bit is ignored; WAIT exit always pulses tx_done_tick.
// STRUCTURE
//  ps2_pkg: typedef enum logic [2:0] {IDLE, RTS, START, DATA, ACK, WAIT} ps2_tx_state_t;
//    localparams PS2_CMD_SET_LEDS=8'hED, PS2_CMD_RESET=8'hFF, PS2_RESP_ACK=8'hFA.
//  Sub-module ps2_line_filter (2-FF sync + 8-sample filter + fall_edge).
//    Instantiated here on ps2c; reusable by the receive path.
// TESTING
//  (Bench uses CLK_FREQ_HZ=1_000_000, so inhibit=100 cycles and timeout=2000 cycles. Device model clocks at 10 kHz.)
//  1. wr_ps2 with din=8'hED -> ps2c_oe high for exactly 100 cycles, then start bit 0.
//     Device sees bits 1,0,1,1,0,1,1,1, parity 1, stop 1. Model acks -> one tx_done_tick, tx_idle=1.
//  2. din=8'h00 -> parity bit 1. din=8'h01 -> parity bit 0. Device-side captured byte equals din in both cases.
//  3. wr_ps2 pulsed during the DATA state of a frame with din=8'hFF -> ignored; exactly one frame (8'hFF) on the bus.
//  4. Device model stops clocking after bit 3 -> 2000 cycles later tx_error pulses, ps2c_oe=ps2d_oe=0, tx_idle=1.
//  5. rst asserted mid-DATA -> next cycle both oe=0, tx_idle=1. A new wr_ps2 with 8'hF4 then completes normally.
//  6. PS2_TX_ACK_CHECK_EN defined, model withholds the ack -> tx_error pulses, no tx_done_tick.
//     Undefined, same stimulus -> tx_done_tick pulses.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions for the keyboard subsystem: transmitter FSM states,
// common command/response codes and small elaboration-time helpers.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RTS,
    START,
    DATA,
    ACK,
    WAIT
  } ps2_tx_state_t;

  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_RESP_ACK     = 8'hFA;

  // Data bits plus parity; the stop bit is a released line, not a stored bit.
  localparam int unsigned PS2_FRAME_BITS = 9;

  // PS/2 uses odd parity: the parity bit makes the total count of ones odd.
  function automatic logic ps2_odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

  // Microseconds to clock cycles, evaluated in 64 bits so large products do not wrap.
  function automatic longint unsigned ps2_us_to_cycles(input longint unsigned clk_hz,
                                                        input longint unsigned us);
    return (us * clk_hz) / 64'd1_000_000;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// PS/2 line conditioner: 2-FF synchroniser, 8-sample glitch filter and a
// one-cycle falling-edge strobe on the filtered level. Used on the PS/2 clock
// pad by the transmitter and reusable by the receive path.
module ps2_line_filter #(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic pad,
  output logic level,
  output logic fall_edge
);

  logic [1:0]            sync_q;
  logic [FILTER_LEN-1:0] hist_q;
  logic                  level_q;
  logic                  fall_q;
  logic                  all_hi;
  logic                  all_lo;

  // Filter window agreement: the level may only move once every sample matches.
  always_comb begin
    all_hi = &hist_q;
    all_lo = ~|hist_q;
  end

  // Synchronise the asynchronous pad; idle bus level is high (released).
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], pad};
    end
  end

  // Sample history of the synchronised pad, newest sample in bit 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q <= '1;
    end else begin
      hist_q <= {hist_q[FILTER_LEN-2:0], sync_q[1]};
    end
  end

  // Filtered level and its 1 -> 0 strobe, both registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      level_q <= 1'b1;
      fall_q  <= 1'b0;
    end else begin
      fall_q <= 1'b0;
      if (all_hi) begin
        level_q <= 1'b1;
      end else if (all_lo) begin
        fall_q  <= level_q;
        level_q <= 1'b0;
      end
    end
  end

  assign level     = level_q;
  assign fall_edge = fall_q;

endmodule

// File: rtl/ps2_tx.sv
// Host-to-device PS/2 transmitter. Sends one command byte to the keyboard by
// inhibiting the clock, issuing a start bit and shifting data/parity on each
// device clock falling edge, then waiting for the bus to return to idle.
// Optional build macro PS2_TX_ACK_CHECK_EN: a missing device ack bit turns the
// final tx_done_tick into a tx_error pulse.
module ps2_tx
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 65_000_000,
  parameter int unsigned INHIBIT_US  = 100,
  parameter int unsigned TIMEOUT_US  = 2000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_ps2,
  input  logic [7:0] din,
  input  logic       ps2c_in,
  input  logic       ps2d_in,
  output logic       ps2c_oe,
  output logic       ps2d_oe,
  output logic       tx_idle,
  output logic       tx_done_tick,
  output logic       tx_error
);

  localparam longint unsigned INHIBIT_CNT =
      ps2_us_to_cycles(64'(CLK_FREQ_HZ), 64'(INHIBIT_US));
  localparam longint unsigned TIMEOUT_CNT =
      ps2_us_to_cycles(64'(CLK_FREQ_HZ), 64'(TIMEOUT_US));
  localparam longint unsigned MAX_CNT =
      (INHIBIT_CNT > TIMEOUT_CNT) ? INHIBIT_CNT : TIMEOUT_CNT;
  localparam int unsigned TIMER_W = (MAX_CNT == 64'd0) ? 1 : $clog2(MAX_CNT + 64'd1);

  localparam logic [TIMER_W-1:0] INHIBIT_LOAD = TIMER_W'(INHIBIT_CNT);
  localparam logic [TIMER_W-1:0] TIMEOUT_LOAD = TIMER_W'(TIMEOUT_CNT);
  localparam logic [TIMER_W-1:0] TIMER_ONE    = TIMER_W'(1);

  ps2_tx_state_t                 state_q;
  logic [PS2_FRAME_BITS-1:0]     frame_q;
  logic [3:0]                    n_q;
  logic [TIMER_W-1:0]            timer_q;
  logic [1:0]                    d_sync_q;
  logic                          c_level;
  logic                          c_fall;
  logic                          timer_expired;
`ifdef PS2_TX_ACK_CHECK_EN
  logic                          ack_q;
`endif

  ps2_line_filter #(
    .FILTER_LEN (8)
  ) u_clk_filter (
    .clk       (clk),
    .rst       (rst),
    .pad       (ps2c_in),
    .level     (c_level),
    .fall_edge (c_fall)
  );

  // The data line only needs synchronising: it is sampled well inside a clock phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      d_sync_q <= 2'b11;
    end else begin
      d_sync_q <= {d_sync_q[0], ps2d_in};
    end
  end

  // Expiry is flagged while the last count is still loaded, so a load of N
  // spans exactly N cycles before the state acts on it.
  always_comb begin
    timer_expired = (timer_q <= TIMER_ONE);
  end

  // Transmit FSM with registered line enables and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      frame_q      <= '0;
      n_q          <= 4'd0;
      timer_q      <= '0;
      ps2c_oe      <= 1'b0;
      ps2d_oe      <= 1'b0;
      tx_idle      <= 1'b1;
      tx_done_tick <= 1'b0;
      tx_error     <= 1'b0;
`ifdef PS2_TX_ACK_CHECK_EN
      ack_q        <= 1'b0;
`endif
    end else begin
      tx_done_tick <= 1'b0;
      tx_error     <= 1'b0;
      unique case (state_q)
        IDLE: begin
          // A strobe coinciding with the done pulse belongs to the finished frame.
          if (wr_ps2 && !tx_done_tick) begin
            frame_q <= {ps2_odd_parity(din), din};
            timer_q <= INHIBIT_LOAD;
            ps2c_oe <= 1'b1;
            ps2d_oe <= 1'b0;
            tx_idle <= 1'b0;
            state_q <= RTS;
          end
        end

        RTS: begin
          if (timer_expired) begin
            ps2c_oe <= 1'b0;
            ps2d_oe <= 1'b1;
            timer_q <= TIMEOUT_LOAD;
            state_q <= START;
          end else begin
            timer_q <= timer_q - TIMER_ONE;
          end
        end

        START: begin
          if (c_fall) begin
            ps2d_oe <= ~frame_q[0];
            n_q     <= 4'd1;
            timer_q <= TIMEOUT_LOAD;
            state_q <= DATA;
          end else if (timer_expired) begin
            ps2c_oe  <= 1'b0;
            ps2d_oe  <= 1'b0;
            tx_error <= 1'b1;
            tx_idle  <= 1'b1;
            state_q  <= IDLE;
          end else begin
            timer_q <= timer_q - TIMER_ONE;
          end
        end

        DATA: begin
          if (c_fall) begin
            timer_q <= TIMEOUT_LOAD;
            if (n_q == 4'd9) begin
              // Stop bit: release the line and let the pull-up supply the 1.
              ps2d_oe <= 1'b0;
              state_q <= ACK;
            end else begin
              ps2d_oe <= ~frame_q[n_q];
              n_q     <= n_q + 4'd1;
            end
          end else if (timer_expired) begin
            ps2c_oe  <= 1'b0;
            ps2d_oe  <= 1'b0;
            tx_error <= 1'b1;
            tx_idle  <= 1'b1;
            state_q  <= IDLE;
          end else begin
            timer_q <= timer_q - TIMER_ONE;
          end
        end

        ACK: begin
          if (c_fall) begin
`ifdef PS2_TX_ACK_CHECK_EN
            ack_q   <= d_sync_q[1];
`endif
            timer_q <= TIMEOUT_LOAD;
            state_q <= WAIT;
          end else if (timer_expired) begin
            ps2c_oe  <= 1'b0;
            ps2d_oe  <= 1'b0;
            tx_error <= 1'b1;
            tx_idle  <= 1'b1;
            state_q  <= IDLE;
          end else begin
            timer_q <= timer_q - TIMER_ONE;
          end
        end

        WAIT: begin
          if (c_level && d_sync_q[1]) begin
`ifdef PS2_TX_ACK_CHECK_EN
            if (ack_q) begin
              tx_error <= 1'b1;
            end else begin
              tx_done_tick <= 1'b1;
            end
`else
            tx_done_tick <= 1'b1;
`endif
            tx_idle <= 1'b1;
            state_q <= IDLE;
          end else if (timer_expired) begin
            ps2c_oe  <= 1'b0;
            ps2d_oe  <= 1'b0;
            tx_error <= 1'b1;
            tx_idle  <= 1'b1;
            state_q  <= IDLE;
          end else begin
            timer_q <= timer_q - TIMER_ONE;
          end
        end

        default: begin
          ps2c_oe <= 1'b0;
          ps2d_oe <= 1'b0;
          tx_idle <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_tx.sv
// Directed bench for ps2_tx at a 1 MHz system clock with a 10 kHz device model.
module tb_ps2_tx;

  localparam int HALF = 50;  // device clock half period in system cycles

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_ps2 = 1'b0;
  logic [7:0] din = 8'h00;
  logic       ps2c_in;
  logic       ps2d_in;
  logic       ps2c_oe;
  logic       ps2d_oe;
  logic       tx_idle;
  logic       tx_done_tick;
  logic       tx_error;

  logic dev_c = 1'b1;
  logic dev_d = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;

  int cyc        = 0;
  int done_cnt   = 0;
  int err_cnt    = 0;
  int err_cyc    = 0;
  int rts_starts = 0;
  int rts_run    = 0;
  int rts_len    = 0;
  logic prev_c_oe = 1'b0;
  int last_fall_cyc = 0;

  // Open-drain bus: either side may pull a line low.
  assign ps2c_in = ~ps2c_oe & dev_c;
  assign ps2d_in = ~ps2d_oe & dev_d;

  always #5 clk = ~clk;

  ps2_tx #(
    .CLK_FREQ_HZ (1_000_000),
    .INHIBIT_US  (100),
    .TIMEOUT_US  (2000)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_ps2       (wr_ps2),
    .din          (din),
    .ps2c_in      (ps2c_in),
    .ps2d_in      (ps2d_in),
    .ps2c_oe      (ps2c_oe),
    .ps2d_oe      (ps2d_oe),
    .tx_idle      (tx_idle),
    .tx_done_tick (tx_done_tick),
    .tx_error     (tx_error)
  );

  // Event counters and clock-inhibit length measurement.
  always @(posedge clk) begin
    cyc       <= cyc + 1;
    prev_c_oe <= ps2c_oe;
    if (tx_done_tick) done_cnt <= done_cnt + 1;
    if (tx_error) begin
      err_cnt <= err_cnt + 1;
      err_cyc <= cyc;
    end
    if (ps2c_oe && !prev_c_oe) rts_starts <= rts_starts + 1;
    if (ps2c_oe) begin
      rts_run <= rts_run + 1;
    end else if (rts_run != 0) begin
      rts_len <= rts_run;
      rts_run <= 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    wr_ps2 = 1'b1;
    din    = b;
    @(posedge clk); #1;
    wr_ps2 = 1'b0;
  endtask

  // Device side: waits for the request-to-send, then clocks up to 11 bits.
  // bits[7:0] data, bits[8] parity, bits[9] stop, all as seen on the wire.
  task automatic device(input int stop_at, input bit give_ack, input bit chk_start,
                        output logic [9:0] bits);
    int waited;
    bits   = '0;
    waited = 0;
    while (!(ps2c_oe == 1'b0 && ps2d_oe == 1'b1) && waited < 1000) begin
      @(posedge clk); #1;
      waited++;
    end
    if (chk_start) begin
      check("request_seen", 32'(waited < 1000), 32'd1);
      check("start_bit_low", 32'(ps2d_in), 32'd0);
    end
    repeat (20) @(posedge clk);
    #1;
    for (int i = 0; i < 11; i++) begin
      if (i == stop_at) break;
      if (i == 10 && give_ack) dev_d = 1'b0;
      dev_c = 1'b0;
      last_fall_cyc = cyc;
      repeat (HALF) @(posedge clk);
      #1;
      if (i < 10) bits[i] = ps2d_in;
      dev_c = 1'b1;
      repeat (HALF) @(posedge clk);
      #1;
    end
    dev_d = 1'b1;
  endtask

  task automatic wait_idle(input string tag, input int limit);
    int k;
    k = 0;
    while (!tx_idle && k < limit) begin
      @(posedge clk); #1;
      k++;
    end
    check(tag, 32'(tx_idle), 32'd1);
    repeat (5) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [9:0] bits;
    int d0, e0, r0, k;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_ps2c_oe", 32'(ps2c_oe), 32'd0);
    check("rst_ps2d_oe", 32'(ps2d_oe), 32'd0);
    check("rst_tx_idle", 32'(tx_idle), 32'd1);
    check("rst_done", 32'(tx_done_tick), 32'd0);
    check("rst_error", 32'(tx_error), 32'd0);
    repeat (20) @(posedge clk);
    #1;

    // 1: set-LEDs command, full frame with ack.
    d0 = done_cnt; e0 = err_cnt;
    send(8'hED);
    check("t1_idle_low", 32'(tx_idle), 32'd0);
    device(99, 1'b1, 1'b1, bits);
    wait_idle("t1_idle_back", 500);
    check("t1_inhibit_len", 32'(rts_len), 32'd100);
    check("t1_byte", 32'(bits[7:0]), 32'hED);
    check("t1_parity", 32'(bits[8]), 32'd1);
    check("t1_stop", 32'(bits[9]), 32'd1);
    check("t1_done", 32'(done_cnt - d0), 32'd1);
    check("t1_no_err", 32'(err_cnt - e0), 32'd0);

    // 2: parity for 00 and 01.
    send(8'h00);
    device(99, 1'b1, 1'b0, bits);
    wait_idle("t2a_idle", 500);
    check("t2a_byte", 32'(bits[7:0]), 32'h00);
    check("t2a_parity", 32'(bits[8]), 32'd1);
    send(8'h01);
    device(99, 1'b1, 1'b0, bits);
    wait_idle("t2b_idle", 500);
    check("t2b_byte", 32'(bits[7:0]), 32'h01);
    check("t2b_parity", 32'(bits[8]), 32'd0);

    // 3: strobe during DATA is dropped.
    d0 = done_cnt; r0 = rts_starts;
    send(8'hFF);
    fork
      device(99, 1'b1, 1'b0, bits);
      begin
        repeat (500) @(posedge clk);
        #1;
        wr_ps2 = 1'b1;
        din    = 8'h00;
        @(posedge clk); #1;
        wr_ps2 = 1'b0;
      end
    join
    wait_idle("t3_idle", 500);
    repeat (300) @(posedge clk);
    #1;
    check("t3_byte", 32'(bits[7:0]), 32'hFF);
    check("t3_parity", 32'(bits[8]), 32'd1);
    check("t3_one_frame", 32'(rts_starts - r0), 32'd1);
    check("t3_done", 32'(done_cnt - d0), 32'd1);

    // 4: device stops clocking after bit 3 -> timeout.
    d0 = done_cnt; e0 = err_cnt;
    send(8'h5A);
    device(4, 1'b1, 1'b0, bits);
    k = 0;
    while (err_cnt == e0 && k < 2600) begin
      @(posedge clk); #1;
      k++;
    end
    check("t4_error", 32'(err_cnt - e0), 32'd1);
    check("t4_latency_window",
          32'((err_cyc - last_fall_cyc) >= 2000 && (err_cyc - last_fall_cyc) <= 2030), 32'd1);
    check("t4_ps2c_oe", 32'(ps2c_oe), 32'd0);
    check("t4_ps2d_oe", 32'(ps2d_oe), 32'd0);
    check("t4_idle", 32'(tx_idle), 32'd1);
    check("t4_no_done", 32'(done_cnt - d0), 32'd0);

    // 5: reset mid-DATA, then a clean frame.
    send(8'hA5);
    device(4, 1'b1, 1'b0, bits);
    rst = 1'b1;
    @(posedge clk); #1;
    check("t5_ps2c_oe", 32'(ps2c_oe), 32'd0);
    check("t5_ps2d_oe", 32'(ps2d_oe), 32'd0);
    check("t5_idle", 32'(tx_idle), 32'd1);
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    d0 = done_cnt; e0 = err_cnt;
    send(8'hF4);
    device(99, 1'b1, 1'b0, bits);
    wait_idle("t5_idle_back", 500);
    check("t5_byte", 32'(bits[7:0]), 32'hF4);
    check("t5_parity", 32'(bits[8]), 32'd0);
    check("t5_done", 32'(done_cnt - d0), 32'd1);
    check("t5_no_err", 32'(err_cnt - e0), 32'd0);

    // 6: device withholds the ack bit.
    begin
      int exp_done, exp_err;
`ifdef PS2_TX_ACK_CHECK_EN
      exp_done = 0; exp_err = 1;
`else
      exp_done = 1; exp_err = 0;
`endif
      d0 = done_cnt; e0 = err_cnt;
      send(8'hAA);
      device(99, 1'b0, 1'b0, bits);
      wait_idle("t6_idle", 500);
      check("t6_byte", 32'(bits[7:0]), 32'hAA);
      check("t6_done", 32'(done_cnt - d0), 32'(exp_done));
      check("t6_error", 32'(err_cnt - e0), 32'(exp_err));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
